// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Purpose : shared sizing helpers for the programmable synchronous FIFO.
//   cnt_width(depth) : bits needed to hold an occupancy of 0..depth
//   ptr_width(depth) : bits needed to address entries 0..depth-1 (at least 1)
// -----------------------------------------------------------------------------
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

  // A depth of 1 would give $clog2 == 0; a zero-width pointer is not legal.
  function automatic int ptr_width(input int depth);
    return ($clog2(depth) < 32'sd1) ? 32'sd1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// -----------------------------------------------------------------------------
// fifo_wrap_ptr
// Purpose : modulo-Depth index counter used for the FIFO read and write
//           pointers. Counts 0..Depth-1 and wraps to 0; no lap bit, since
//           occupancy is tracked separately.
// Ports   :
//   clk      in   clock
//   reset_n  in   synchronous active-low reset (ptr -> 0)
//   clr      in   synchronous clear (ptr -> 0), wins over inc
//   inc      in   advance by one entry
//   ptr      out  current index
// -----------------------------------------------------------------------------
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int Depth = 6,
  parameter int PtrW  = ptr_width(Depth)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            inc,
  output logic [PtrW-1:0] ptr
);

  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 32'sd1);

  logic [PtrW-1:0] r_ptr;

  // Pointer register: reset/clear to zero, otherwise advance with wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == LastIdx) ? '0 : r_ptr + PtrW'(1'b1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_prog.sv
// -----------------------------------------------------------------------------
// fifo_prog
// Purpose : synchronous FIFO of arbitrary depth with occupancy count,
//           programmable almost-full/almost-empty thresholds, synchronous
//           flush, push-on-full when a pop happens in the same cycle, and
//           sticky overflow/underflow flags.
// Ports   :
//   clk, reset_n               clock, synchronous active-low reset
//   data_in, push              write data and write request
//   pop                        read request
//   data_out                   head-of-queue word (valid while empty=0)
//   flush                      discard all contents (wins over push/pop)
//   af_level, ae_level         almost-full / almost-empty thresholds
//   err_clr                    clear sticky error flags
//   count                      occupancy 0..Depth
//   full, empty                count==Depth / count==0
//   almost_full, almost_empty  count>=af_level / count<=ae_level
//   overflow, underflow        sticky: push dropped / pop while empty
// -----------------------------------------------------------------------------
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 6,
  parameter int CntW  = cnt_width(Depth)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  output logic [Width-1:0] data_out,
  input  logic             flush,
  input  logic [CntW-1:0]  af_level,
  input  logic [CntW-1:0]  ae_level,
  input  logic             err_clr,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int              PtrW     = ptr_width(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [CntW-1:0]  r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [PtrW-1:0]  w_rd_ptr;
  logic [PtrW-1:0]  w_wr_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_ovf_set;
  logic             w_udf_set;

  assign w_full    = (r_count == DepthCnt);
  assign w_empty   = (r_count == '0);

  // A push into a full FIFO is accepted only when a pop frees a slot in the
  // same cycle; an empty FIFO never bypasses push data to the output.
  assign w_pop_ok  = pop & ~w_empty;
  assign w_push_ok = push & (~w_full | w_pop_ok);

  // Flush overrides both ports, and what it discards is not an error.
  assign w_wr_en   = w_push_ok & ~flush;
  assign w_rd_en   = w_pop_ok & ~flush;
  assign w_ovf_set = push & ~w_push_ok & ~flush;
  assign w_udf_set = pop & w_empty & ~flush;

  fifo_wrap_ptr #(.Depth(Depth), .PtrW(PtrW)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (flush),
    .inc     (w_rd_en),
    .ptr     (w_rd_ptr)
  );

  fifo_wrap_ptr #(.Depth(Depth), .PtrW(PtrW)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (flush),
    .inc     (w_wr_en),
    .ptr     (w_wr_ptr)
  );

  // Storage write; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_ptr] <= data_in;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CntW'(1'b1);
        2'b01:   r_count <= r_count - CntW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~err_clr);
      r_underflow <= w_udf_set | (r_underflow & ~err_clr);
    end
  end

  // Thresholds are compared live, so a threshold change shows immediately.
  assign data_out     = r_mem[w_rd_ptr];
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_level);
  assign almost_empty = (r_count <= ae_level);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_fifo_prog
// Self-checking bench for fifo_prog (Width=32, Depth=6). A table of
// single-cycle vectors covers fill, overflow, drain and threshold decode;
// hand-written sequences cover wrap, simultaneous push/pop, threshold
// changes, flush and reset mid-operation. Expected read data comes from a
// scoreboard queue filled when the bench issues an accepted push.
// -----------------------------------------------------------------------------
module tb_fifo_prog;

  localparam int WIDTH = 32;
  localparam int DEPTH = 6;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             flush;
  logic [CNTW-1:0]  af_level;
  logic [CNTW-1:0]  ae_level;
  logic             err_clr;
  logic [CNTW-1:0]  count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  fifo_prog #(.Width(WIDTH), .Depth(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .data_out     (data_out),
    .flush        (flush),
    .af_level     (af_level),
    .ae_level     (ae_level),
    .err_clr      (err_clr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            push;
    logic            pop;
    logic            err_clr;
    logic [31:0]     data;
    logic [CNTW-1:0] cnt;
    logic            full;
    logic            empty;
    logic            af;
    logic            ae;
    logic            ovf;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus. Before the edge the head word is compared
  // with the scoreboard for every pop the reference rules accept.
  task automatic cycle(input logic p, input logic q, input logic f, input logic c,
                       input logic [31:0] d);
    bit pop_ok;
    bit push_ok;
    push    = p;
    pop     = q;
    flush   = f;
    err_clr = c;
    data_in = d;
    pop_ok  = q && (sb.size() != 0);
    push_ok = p && ((sb.size() != DEPTH) || pop_ok);
    if (f) begin
      sb.delete();
    end else begin
      if (pop_ok) check("data_out", data_out, sb.pop_front());
      if (push_ok) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    // vector table: push, pop, err_clr, data, count, full, empty, af, ae, ovf
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'hA0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'hA1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'hA2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'hA3, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'hA4, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'hA5, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'hFF, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset_n  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
    data_in  = 32'h0;
    af_level = 3'd4;
    ae_level = 3'd1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst.count", 32'(count), 32'd0);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full", 32'(full), 32'd0);
    check("rst.almost_empty", 32'(almost_empty), 32'd1);
    check("rst.almost_full", 32'(almost_full), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    check("rst.underflow", 32'(underflow), 32'd0);

    // Fill, overflow, drain and threshold decode from the vector table
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].push, tbl[i].pop, 1'b0, tbl[i].err_clr, tbl[i].data);
      check($sformatf("tbl[%0d].count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl[%0d].full", i), 32'(full), 32'(tbl[i].full));
      check($sformatf("tbl[%0d].empty", i), 32'(empty), 32'(tbl[i].empty));
      check($sformatf("tbl[%0d].almost_full", i), 32'(almost_full), 32'(tbl[i].af));
      check($sformatf("tbl[%0d].almost_empty", i), 32'(almost_empty), 32'(tbl[i].ae));
      check($sformatf("tbl[%0d].overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("tbl[%0d].underflow", i), 32'(underflow), 32'd0);
    end

    // Wrap: push 4, pop 4, push 6 so the write pointer crosses 5->0
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hD0 + 32'(i));
    check("wrap.count4", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap.count0a", 32'(count), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hE0 + 32'(i));
    check("wrap.count6", 32'(count), 32'd6);
    check("wrap.full", 32'(full), 32'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap.count0b", 32'(count), 32'd0);
    check("wrap.sb_empty", 32'(sb.size()), 32'd0);

    // Push + pop while full: both accepted, B0 comes out last
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hA0 + 32'(i));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hB0);
    check("fullpp.count", 32'(count), 32'd6);
    check("fullpp.overflow", 32'(overflow), 32'd0);
    check("fullpp.tail", sb[5], 32'hB0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("fullpp.empty", 32'(empty), 32'd1);

    // Push + pop while empty: push only, underflow set
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h55);
    check("emptypp.count", 32'(count), 32'd1);
    check("emptypp.underflow", 32'(underflow), 32'd1);
    check("emptypp.data_out", data_out, 32'h55);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("errclr.overflow", 32'(overflow), 32'd0);
    check("errclr.underflow", 32'(underflow), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    // set and clear in the same cycle: set wins
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    check("setwins.underflow", 32'(underflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("setwins.cleared", 32'(underflow), 32'd0);

    // Live threshold changes at count 3
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h70 + 32'(i));
    check("thr.af_at3", 32'(almost_full), 32'd0);
    af_level = 3'd2;
    #1;
    check("thr.af_lvl2", 32'(almost_full), 32'd1);
    af_level = 3'd0;
    #1;
    check("thr.af_lvl0", 32'(almost_full), 32'd1);
    af_level = 3'd4;
    ae_level = 3'd6;
    #1;
    check("thr.ae_lvl6", 32'(almost_empty), 32'd1);
    ae_level = 3'd1;
    #1;
    check("thr.ae_lvl1", 32'(almost_empty), 32'd0);

    // Flush with push and pop in the same cycle at count 3
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h77);
    check("flush.count", 32'(count), 32'd0);
    check("flush.empty", 32'(empty), 32'd1);
    check("flush.overflow", 32'(overflow), 32'd0);
    check("flush.underflow", 32'(underflow), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hC1);
    check("flush.data_c1", data_out, 32'hC1);
    check("flush.count1", 32'(count), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Flush with push while full: dropped push is not an overflow
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h90 + 32'(i));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h99);
    check("flushfull.overflow", 32'(overflow), 32'd0);
    check("flushfull.count", 32'(count), 32'd0);
    // pointers restart at 0 after a flush from a non-zero position
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h5A);
    check("flushfull.head", data_out, 32'h5A);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Reset mid-operation, with a push pending on the reset edge
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h31);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h32);
    push    = 1'b1;
    data_in = 32'h33;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push    = 1'b0;
    sb.delete();
    check("midrst.count", 32'(count), 32'd0);
    check("midrst.empty", 32'(empty), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h3C);
    check("midrst.head", data_out, 32'h3C);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("midrst.final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
- Next-generation synchronous FIFO for the bridge datapath.
- Adds these over the base FIFO:
  - arbitrary (non-power-of-2) depth
  - explicit occupancy count
  - runtime-programmable almost-full and almost-empty thresholds
  - synchronous flush
  - push-on-full when a pop happens in the same cycle
  - sticky overflow/underflow error flags
- Used as the AXI/AHB request/response buffer where the back-pressure thresholds are set by control logic.

Parameters:
- Width, 32, data word width in bits (>=1).
- Depth, 6, number of entries; any value >=2.
- CntW, $clog2(Depth+1), derived; width of count and threshold ports. Must not be overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- data_in  in  Width  write data.
- push  in  1  write request.
- pop  in  1  read request.
- data_out  out  Width  head-of-queue word; valid only while empty=0.
- flush  in  1  discard all contents.
- af_level  in  CntW  almost-full threshold.
- ae_level  in  CntW  almost-empty threshold.
- err_clr  in  1  clears sticky error flags.
- count  out  CntW  current occupancy, 0..Depth.
- full  out  1  count==Depth.
- empty  out  1  count==0.
- almost_full  out  1  count>=af_level.
- almost_empty  out  1  count<=ae_level.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was issued while empty.

Behaviour:
- Reset:
  - Synchronous: reset_n sampled low at a rising edge clears r_ptr, w_ptr, count, overflow and underflow.
  - After reset: empty=1, full=0, count=0.
  - Storage array is not reset; data_out is undefined while empty.
- Pointers:
  - r_ptr and w_ptr are ceil(log2 Depth) bits wide.
  - Each increments by 1 and wraps from Depth-1 to 0; no lap bit.
  - count is a separate register.
- Accept rules (from registered state plus this cycle's inputs):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
- Effects at the clock edge:
  - push_ok: store data_in at w_ptr and advance w_ptr.
  - pop_ok: advance r_ptr.
  - count += push_ok - pop_ok.
- Simultaneous push+pop:
  - When full, both are accepted and count stays at Depth; data_out shows the old head this cycle.
  - When empty, only the push is accepted (no fall-through bypass), count becomes 1, and underflow is set.
- Read path:
  - data_out = storage[r_ptr], combinational from registered state.
  - Zero-latency head view; a written word is visible the cycle after the push.
- Status flags:
  - full, empty, almost_full and almost_empty are decoded combinationally from the count register plus the live thresholds.
  - They change the cycle after the causing edge, or immediately when af_level/ae_level change.
  - af_level=0 forces almost_full=1.
  - ae_level>=Depth forces almost_empty=1.
- Flush:
  - flush=1 at an edge sets r_ptr=w_ptr=0 and count=0.
  - Overrides push and pop in the same cycle; the push data is discarded.
  - No error flag is set by the discarded push or pop.
- Errors:
  - overflow sets on push & ~push_ok & ~flush.
  - underflow sets on pop & empty & ~flush.
  - Both stay set until err_clr or reset.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Priority: reset > flush > push/pop.
- Reset mid-operation: all contents are lost; no partial state survives.

Decomposition:
- Package fifo_pkg holds:
  - function cnt_width(depth) returning $clog2(depth+1)
  - function ptr_width(depth) returning max(1,$clog2(depth))
- Sub-module fifo_wrap_ptr (parameter Depth; inputs clk, reset_n, clr, inc; output ptr):
  - A modulo-Depth counter.
  - Instantiated once for r_ptr and once for w_ptr.
- Storage array, count register, flag decode and error registers live in fifo_prog.

Test Plan:
- Reset: Depth=6, ae_level=1, af_level=4, reset_n low 2 cycles -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0.
- Fill/overflow/drain:
  - Push 0xA0..0xA5 -> full=1, count=6.
  - Push 0xFF -> dropped, overflow=1.
  - 6 pops -> data_out A0..A5 in order, then empty=1.
- Wrap: push 4, pop 4, push 6 (w_ptr crosses 5->0) -> pops return exact order, count returns to 0.
- Simultaneous events:
  - Full with push 0xB0 + pop -> A0 read, count stays 6, overflow stays 0, B0 emerges last.
  - Empty with push+pop -> count=1, underflow=1.
  - Then err_clr -> both flags 0.
- Thresholds: af_level=4, ae_level=1, step count 0..6 -> almost_full asserts at count 4,5,6; almost_empty only at count 0,1; changing af_level to 2 at count 3 -> almost_full=1 the same cycle.
- Flush: count=3, flush+push+pop in one cycle -> next cycle count=0, empty=1, no error flags; subsequent push 0xC1 -> data_out=0xC1.
